mem_port_arbiter: RTL

- Shares one single-port, variable-latency memory between the instruction-fetch stage and the data-memory stage (the stage after address calculation).
- Data requests have priority, with a one-slot anti-starvation rule for fetch.
- Drives a req/ack memory handshake, returns read data to the winning requester, and raises a pipeline stall while a data access is outstanding.
- Aborts accesses that exceed a timeout.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and data access.
// Data has priority; after a data grant, a waiting fetch gets the next slot. Accesses abort after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic        stall,
    output logic [1:0]  dbg_state
);

    // Handshake: mem_req stays high with stable mem_we/mem_addr/mem_wdata until
    // an edge that samples mem_ack=1 (transfer done, mem_rdata taken on that
    // edge) or until the wait counter expires. An ack seen while idle is ignored.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_dm, last_dm_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [31:0]       mem_addr_nxt, mem_wdata_nxt;
    logic [31:0]       if_rdata_nxt, dm_rdata_nxt;
    logic              if_done_nxt, dm_done_nxt, bus_err_nxt;
    logic              if_elig, dm_elig, expired;

    assign stall     = dm_req & ~dm_done;
    assign dbg_state = state;

    // A requester is still holding req during its done cycle; that is not a new request.
    assign if_elig = if_req & ~if_done;
    assign dm_elig = dm_req & ~dm_done;
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt     = state;
        last_dm_nxt   = last_dm;
        cnt_nxt       = cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_done_nxt   = 1'b0;
        dm_done_nxt   = 1'b0;
        bus_err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (dm_elig && !(last_dm && if_elig)) begin
                    state_nxt     = BUSY_DM;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    cnt_nxt       = '0;
                    last_dm_nxt   = 1'b1;
                end else if (if_elig) begin
                    state_nxt    = BUSY_IF;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = if_addr;
                    cnt_nxt      = '0;
                    last_dm_nxt  = 1'b0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    if (state == BUSY_IF) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end else begin
                        dm_done_nxt = 1'b1;
                        if (!mem_we) dm_rdata_nxt = mem_rdata;
                    end
                end else if (expired) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    bus_err_nxt = 1'b1;
                    if (state == BUSY_IF) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = '0;
                    end else begin
                        dm_done_nxt  = 1'b1;
                        dm_rdata_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_dm   <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_dm   <= last_dm_nxt;
            cnt       <= cnt_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
            if_done   <= if_done_nxt;
            dm_done   <= dm_done_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

endmodule
